// File: rtl/oam_dma_if.sv
// Bus bundle for the sprite DMA engine: CPU-bus snoop inputs plus the DMA bus-master side.
interface oam_dma_if;
  logic [15:0] i_bus_addr;
  logic        i_bus_wn;
  logic [7:0]  i_bus_wdata;
  logic        o_cpu_halt;
  logic        o_dma_active;
  logic [15:0] o_dma_addr;
  logic        o_dma_wn;
  logic [7:0]  o_dma_wdata;
  logic [7:0]  i_dma_rdata;
  logic        o_dma_done;

  // DMA engine side
  modport master (
    input  i_bus_addr, i_bus_wn, i_bus_wdata, i_dma_rdata,
    output o_cpu_halt, o_dma_active, o_dma_addr, o_dma_wn, o_dma_wdata, o_dma_done
  );

  // System side (CPU bus, bus mux, memory)
  modport slave (
    output i_bus_addr, i_bus_wn, i_bus_wdata, i_dma_rdata,
    input  o_cpu_halt, o_dma_active, o_dma_addr, o_dma_wn, o_dma_wdata, o_dma_done
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA engine ($4014): halts the CPU and copies one page of CPU memory to OAMDATA.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_PORT_ADDR = 16'h2004,
  parameter int unsigned XFER_CNT      = 256
) (
  input  logic      i_cpu_clk,
  input  logic      i_cpu_rstn,
  oam_dma_if.master bus
);

  localparam logic [9:0] XFER_LIM = 10'(XFER_CNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        par_q, par_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  data_q, data_d;
  logic [9:0]  cnt_inc;

  logic        halt_q, halt_d;
  logic        active_q, active_d;
  logic [15:0] addr_q, addr_d;
  logic        wn_q, wn_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        done_q, done_d;

  assign cnt_inc = {1'b0, cnt_q} + 10'd1;

  // State register: FSM, datapath and registered outputs, async active-low reset
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      state_q  <= S_IDLE;
      par_q    <= 1'b0;
      cnt_q    <= '0;
      page_q   <= '0;
      data_q   <= '0;
      halt_q   <= 1'b0;
      active_q <= 1'b0;
      addr_q   <= '0;
      wn_q     <= 1'b1;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
      page_q   <= page_d;
      data_q   <= data_d;
      halt_q   <= halt_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      wn_q     <= wn_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: trigger detect, parity alignment, read/write byte loop
  always_comb begin
    state_d = state_q;
    par_d   = ~par_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_bus_addr == DMA_REG_ADDR && !bus.i_bus_wn) begin
          page_d  = bus.i_bus_wdata;
          cnt_d   = '0;
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = par_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        data_d  = bus.i_dma_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d   = cnt_inc[8:0];
        state_d = (cnt_inc < XFER_LIM) ? S_READ : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: from the upcoming state so the registered outputs line up with it
  always_comb begin
    halt_d   = 1'b0;
    active_d = 1'b0;
    addr_d   = '0;
    wn_d     = 1'b1;
    wdata_d  = '0;
    done_d   = 1'b0;
    unique case (state_d)
      S_HALT: halt_d = 1'b1;
      S_ALIGN: begin
        halt_d   = 1'b1;
        active_d = 1'b1;
      end
      S_READ: begin
        halt_d   = 1'b1;
        active_d = 1'b1;
        addr_d   = {page_d, cnt_d[7:0]};
      end
      S_WRITE: begin
        halt_d   = 1'b1;
        active_d = 1'b1;
        wn_d     = 1'b0;
        addr_d   = OAM_PORT_ADDR;
        wdata_d  = data_d;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_cpu_halt   = halt_q;
  assign bus.o_dma_active = active_q;
  assign bus.o_dma_addr   = addr_q;
  assign bus.o_dma_wn     = wn_q;
  assign bus.o_dma_wdata  = wdata_q;
  assign bus.o_dma_done   = done_q;

endmodule
